ram_line_bridge: RTL and testbench

- Main-memory side of the cache: consumes the cache controller's RAMreadEnable/RAMwriteEnable requests and produces its dataReady.
- Moves whole cache lines between the cache data array and a word-wide synchronous main RAM with fixed read latency.
- Write-backs are latched from a one-cycle pulse and drained word by word. Line fills are assembled word by word, then flagged with a one-cycle dataReady pulse.

---
 rtl/ram_line_bridge_pkg.sv | 24 ++
 rtl/ram_line_bridge_chk.sv | 15 +
 rtl/ram_line_bridge_latch.sv | 54 +++++
 rtl/ram_line_bridge.sv | 207 ++++++++++++++++++++
 tb/tb_ram_line_bridge.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_line_bridge_pkg.sv
// Shared definitions for the cache-line <-> main-RAM bridge: FSM encoding,
// default geometry and the line-base address helper.
package ram_line_bridge_pkg;

    localparam int DEF_ADDR_WIDTH     = 16;
    localparam int DEF_DATA_WIDTH     = 16;
    localparam int DEF_WORDS_PER_LINE = 4;
    localparam int DEF_RAM_LATENCY    = 3;
    localparam int DEF_LINE_WIDTH     = DEF_WORDS_PER_LINE * DEF_DATA_WIDTH;

    typedef enum logic [4:0] {
        ST_IDLE    = 5'b00001,
        ST_WR_WORD = 5'b00010,
        ST_RD_REQ  = 5'b00100,
        ST_RD_WAIT = 5'b01000,
        ST_DONE    = 5'b10000
    } state_t;

    // Clears the word-offset bits so word indices can be OR-ed in without carry.
    function automatic logic [31:0] line_base(input logic [31:0] addr, input int unsigned obits);
        line_base = addr & ~((32'd1 << obits) - 32'd1);
    endfunction

endpackage

// File: rtl/ram_line_bridge_chk.sv
// Protocol checker for the bridge: no write pulse during a write-back drain,
// and dataReady never lasts more than one cycle.
module ram_line_bridge_chk (
    input logic clk,
    input logic reset,
    input logic wr_active,
    input logic wr_pulse,
    input logic data_ready
);

    a_no_wr_during_drain: assert property (@(posedge clk) disable iff (reset) !(wr_active && wr_pulse));

    a_ready_single_cycle: assert property (@(posedge clk) disable iff (reset) data_ready |=> !data_ready);

endmodule

// File: rtl/ram_line_bridge_latch.sv
// Write-back line buffer: captures a victim line and its base address on a
// pulse and presents the word selected by index, bypassing the capture cycle.
module ram_line_latch
    import ram_line_bridge_pkg::*;
#(
    parameter int AW  = DEF_ADDR_WIDTH,
    parameter int DW  = DEF_DATA_WIDTH,
    parameter int WPL = DEF_WORDS_PER_LINE
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     capture,
    input  logic [AW-1:0]            addr,
    input  logic [WPL*DW-1:0]        line,
    input  logic [$clog2(WPL)-1:0]   idx,
    output logic [AW-1:0]            base,
    output logic [DW-1:0]            word
);

    localparam int OBITS = $clog2(WPL);

    logic [AW-1:0]     addr_r;
    logic [WPL*DW-1:0] line_r;
    logic [AW-1:0]     view_addr_s;
    logic [WPL*DW-1:0] view_line_s;

    // Hold the victim line until the next accepted capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_r <= {AW{1'b0}};
            line_r <= {(WPL*DW){1'b0}};
        end else if (capture) begin
            addr_r <= addr;
            line_r <= line;
        end else begin
            addr_r <= addr_r;
            line_r <= line_r;
        end
    end

    // The FSM loads word 0 in the same edge the line is captured, hence the bypass.
    always_comb begin
        if (capture) begin
            view_addr_s = addr;
            view_line_s = line;
        end else begin
            view_addr_s = addr_r;
            view_line_s = line_r;
        end
        base = AW'(line_base(32'(view_addr_s), OBITS));
        word = view_line_s[int'(idx)*DW +: DW];
    end

endmodule

// File: rtl/ram_line_bridge.sv
// Main-memory side of the cache: drains latched write-back lines and
// assembles line fills word by word from a fixed-latency synchronous RAM.
module ram_line_bridge
    import ram_line_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int RAM_LATENCY    = DEF_RAM_LATENCY
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 RAMreadEnable,
    input  logic                                 RAMwriteEnable,
    input  logic [ADDR_WIDTH-1:0]                readAddr,
    input  logic [ADDR_WIDTH-1:0]                writeAddr,
    input  logic [WORDS_PER_LINE*DATA_WIDTH-1:0] writeLine,
    output logic [WORDS_PER_LINE*DATA_WIDTH-1:0] readLine,
    output logic                                 dataReady,
    output logic                                 busy,
    output logic [ADDR_WIDTH-1:0]                memAddr,
    output logic [DATA_WIDTH-1:0]                memWData,
    output logic                                 memWE,
    output logic                                 memRE,
    input  logic [DATA_WIDTH-1:0]                memRData
);

    localparam int OBITS = $clog2(WORDS_PER_LINE);
    localparam int LBITS = $clog2(RAM_LATENCY + 1);
    localparam int LW    = WORDS_PER_LINE * DATA_WIDTH;

    localparam logic [OBITS-1:0] WORD_ONE  = OBITS'(32'd1);
    localparam logic [OBITS-1:0] WORD_LAST = OBITS'(WORDS_PER_LINE - 1);
    localparam logic [LBITS-1:0] LAT_ONE   = LBITS'(32'd1);
    localparam logic [LBITS-1:0] LAT_LAST  = LBITS'(RAM_LATENCY - 1);

    state_t                  state_r;
    logic                    pend_wr_r;
    logic                    pend_rd_r;
    logic                    rd_prev_r;
    logic [ADDR_WIDTH-1:0]   rd_base_r;
    logic [OBITS-1:0]        word_cnt_r;
    logic [LBITS-1:0]        lat_cnt_r;
    logic [LW-1:0]           read_line_r;
    logic                    data_ready_r;
    logic                    mem_we_r;
    logic                    mem_re_r;
    logic [ADDR_WIDTH-1:0]   mem_addr_r;
    logic [DATA_WIDTH-1:0]   mem_wdata_r;

    logic                    cap_wr_s;
    logic                    rd_edge_s;
    logic                    wr_pend_s;
    logic                    rd_pend_s;
    logic [ADDR_WIDTH-1:0]   rd_base_s;
    logic [OBITS-1:0]        next_cnt_s;
    logic [OBITS-1:0]        wr_idx_s;
    logic [ADDR_WIDTH-1:0]   wr_base_s;
    logic [DATA_WIDTH-1:0]   wr_word_s;

    // Request decode; the write latch is frozen while a drain is in flight.
    always_comb begin
        cap_wr_s   = RAMwriteEnable && (state_r != ST_WR_WORD);
        rd_edge_s  = RAMreadEnable && !rd_prev_r;
        wr_pend_s  = pend_wr_r || cap_wr_s;
        rd_pend_s  = pend_rd_r || rd_edge_s;
        next_cnt_s = word_cnt_r + WORD_ONE;
        if (pend_rd_r) begin
            rd_base_s = rd_base_r;
        end else begin
            rd_base_s = ADDR_WIDTH'(line_base(32'(readAddr), OBITS));
        end
        if (state_r == ST_WR_WORD) begin
            wr_idx_s = next_cnt_s;
        end else begin
            wr_idx_s = {OBITS{1'b0}};
        end
    end

    ram_line_latch #(
        .AW  (ADDR_WIDTH),
        .DW  (DATA_WIDTH),
        .WPL (WORDS_PER_LINE)
    ) u_latch (
        .clk     (clk),
        .reset   (reset),
        .capture (cap_wr_s),
        .addr    (writeAddr),
        .line    (writeLine),
        .idx     (wr_idx_s),
        .base    (wr_base_s),
        .word    (wr_word_s)
    );

    // Transfer FSM; RAM strobes are loaded together with the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            pend_wr_r    <= 1'b0;
            pend_rd_r    <= 1'b0;
            rd_prev_r    <= 1'b0;
            rd_base_r    <= {ADDR_WIDTH{1'b0}};
            word_cnt_r   <= {OBITS{1'b0}};
            lat_cnt_r    <= {LBITS{1'b0}};
            read_line_r  <= {LW{1'b0}};
            data_ready_r <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_re_r     <= 1'b0;
            mem_addr_r   <= {ADDR_WIDTH{1'b0}};
            mem_wdata_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            rd_prev_r <= RAMreadEnable;
            if (cap_wr_s) begin
                pend_wr_r <= 1'b1;
            end
            if (rd_edge_s && !pend_rd_r) begin
                pend_rd_r <= 1'b1;
                rd_base_r <= rd_base_s;
            end
            case (state_r)
                ST_IDLE: begin
                    if (wr_pend_s) begin
                        state_r     <= ST_WR_WORD;
                        word_cnt_r  <= {OBITS{1'b0}};
                        mem_we_r    <= 1'b1;
                        mem_addr_r  <= wr_base_s | ADDR_WIDTH'(wr_idx_s);
                        mem_wdata_r <= wr_word_s;
                    end else if (rd_pend_s) begin
                        state_r    <= ST_RD_REQ;
                        word_cnt_r <= {OBITS{1'b0}};
                        mem_re_r   <= 1'b1;
                        mem_addr_r <= rd_base_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WR_WORD: begin
                    if (word_cnt_r == WORD_LAST) begin
                        pend_wr_r <= 1'b0;
                        mem_we_r  <= 1'b0;
                        if (rd_pend_s) begin
                            state_r    <= ST_RD_REQ;
                            word_cnt_r <= {OBITS{1'b0}};
                            mem_re_r   <= 1'b1;
                            mem_addr_r <= rd_base_s;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        word_cnt_r  <= next_cnt_s;
                        mem_addr_r  <= wr_base_s | ADDR_WIDTH'(wr_idx_s);
                        mem_wdata_r <= wr_word_s;
                    end
                end
                ST_RD_REQ: begin
                    mem_re_r  <= 1'b0;
                    lat_cnt_r <= {LBITS{1'b0}};
                    state_r   <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (lat_cnt_r == LAT_LAST) begin
                        read_line_r[int'(word_cnt_r)*DATA_WIDTH +: DATA_WIDTH] <= memRData;
                        if (word_cnt_r == WORD_LAST) begin
                            state_r      <= ST_DONE;
                            data_ready_r <= 1'b1;
                        end else begin
                            word_cnt_r <= next_cnt_s;
                            mem_re_r   <= 1'b1;
                            mem_addr_r <= rd_base_r | ADDR_WIDTH'(next_cnt_s);
                            state_r    <= ST_RD_REQ;
                        end
                    end else begin
                        lat_cnt_r <= lat_cnt_r + LAT_ONE;
                    end
                end
                ST_DONE: begin
                    data_ready_r <= 1'b0;
                    pend_rd_r    <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    mem_we_r     <= 1'b0;
                    mem_re_r     <= 1'b0;
                    data_ready_r <= 1'b0;
                end
            endcase
        end
    end

    ram_line_bridge_chk u_chk (
        .clk        (clk),
        .reset      (reset),
        .wr_active  (state_r == ST_WR_WORD),
        .wr_pulse   (RAMwriteEnable),
        .data_ready (data_ready_r)
    );

    assign readLine  = read_line_r;
    assign dataReady = data_ready_r;
    assign busy      = (state_r != ST_IDLE) || pend_wr_r;
    assign memAddr   = mem_addr_r;
    assign memWData  = mem_wdata_r;
    assign memWE     = mem_we_r;
    assign memRE     = mem_re_r;

endmodule

// File: tb/tb_ram_line_bridge.sv
// Self-checking bench for ram_line_bridge: directed and random line fills and
// write-backs against a word-addressed memory model, plus a 2-word/latency-1 build.
module tb_ram_line_bridge;

    localparam int LAT  = 3;
    localparam int LAT2 = 1;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        int          cyc;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        re, we, dr, busy, mwe, mre;
    logic [15:0] raddr, waddr, maddr, mwdata, mrdata;
    logic [63:0] wline, rline;
    logic        re2, we2, dr2, busy2, mwe2, mre2;
    logic [15:0] raddr2, waddr2, maddr2, mwdata2, mrdata2;
    logic [31:0] wline2, rline2;
    logic        bd_we;
    logic [15:0] bd_addr, bd_data;

    logic [15:0] ram1 [0:65535];
    logic [15:0] ram2 [0:65535];
    logic [15:0] pipe1 [0:LAT-1];
    logic [15:0] pipe2 [0:LAT2-1];

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    ev_t         wr_q[$];
    ev_t         rd_q[$];
    int          dr_q[$];
    int          rd2_q[$];
    int          dr2_q[$];
    logic [15:0] exp_mem [int];
    logic [15:0] bases[$];

    always #5 clk = ~clk;

    ram_line_bridge #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .WORDS_PER_LINE(4), .RAM_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .RAMreadEnable(re), .RAMwriteEnable(we),
        .readAddr(raddr), .writeAddr(waddr), .writeLine(wline), .readLine(rline),
        .dataReady(dr), .busy(busy), .memAddr(maddr), .memWData(mwdata),
        .memWE(mwe), .memRE(mre), .memRData(mrdata)
    );

    ram_line_bridge #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .WORDS_PER_LINE(2), .RAM_LATENCY(LAT2)) dut2 (
        .clk(clk), .reset(reset), .RAMreadEnable(re2), .RAMwriteEnable(we2),
        .readAddr(raddr2), .writeAddr(waddr2), .writeLine(wline2), .readLine(rline2),
        .dataReady(dr2), .busy(busy2), .memAddr(maddr2), .memWData(mwdata2),
        .memWE(mwe2), .memRE(mre2), .memRData(mrdata2)
    );

    // Synchronous RAM with fixed read latency; idle pipeline slots carry a marker.
    always @(posedge clk) begin
        if (mwe) ram1[maddr] <= mwdata;
        else if (bd_we) ram1[bd_addr] <= bd_data;
        if (mwe2) ram2[maddr2] <= mwdata2;
        else if (bd_we) ram2[bd_addr] <= bd_data;
        pipe1[0] <= mre ? ram1[maddr] : 16'hDEAD;
        for (int i = 1; i < LAT; i++) pipe1[i] <= pipe1[i-1];
        pipe2[0] <= mre2 ? ram2[maddr2] : 16'hDEAD;
    end
    assign mrdata  = pipe1[LAT-1];
    assign mrdata2 = pipe2[LAT2-1];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (mwe) wr_q.push_back('{maddr, mwdata, cyc});
        if (mre) rd_q.push_back('{maddr, 16'h0000, cyc});
        if (dr) dr_q.push_back(cyc);
        if (mre2) rd2_q.push_back(cyc);
        if (dr2) dr2_q.push_back(cyc);
    endtask

    task automatic clr();
        wr_q.delete(); rd_q.delete(); dr_q.delete(); rd2_q.delete(); dr2_q.delete();
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin tick(); n++; end
        check("idle_timeout", {63'd0, busy}, 64'd0);
    endtask

    task automatic wait_dr(input int budget);
        int n = 0;
        int start = dr_q.size();
        while (dr_q.size() == start && n < budget) begin tick(); n++; end
        check("ready_timeout", {63'd0, dr_q.size() > start}, 64'd1);
    endtask

    function automatic logic [63:0] exp_line(input logic [15:0] a);
        logic [63:0] r;
        logic [15:0] b;
        b = a & 16'hFFFC;
        for (int i = 0; i < 4; i++) r[i*16 +: 16] = exp_mem[int'(b) + i];
        return r;
    endfunction

    function automatic int first_gap(input int later, input int earlier_valid, input int earlier);
        return (earlier_valid != 0) ? later - earlier : -1;
    endfunction

    initial begin
        logic [63:0] line, exp_rline;
        logic [15:0] b, rb;
        int          c0, op;

        reset = 1'b1; re = 1'b0; we = 1'b0; raddr = 16'h0000; waddr = 16'h0000; wline = 64'd0;
        re2 = 1'b0; we2 = 1'b0; raddr2 = 16'h0000; waddr2 = 16'h0000; wline2 = 32'd0;
        bd_we = 1'b0; bd_addr = 16'h0000; bd_data = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_strobes", {60'd0, dr, busy, mwe, mre}, 64'd0);
        check("rst_addr", {48'd0, maddr}, 64'd0);
        check("rst_wdata", {48'd0, mwdata}, 64'd0);
        check("rst_line", rline, 64'd0);
        check("rst_dut2", {29'd0, rline2, dr2, mwe2, mre2}, 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            bd_we = 1'b1; bd_addr = 16'h0040 + 16'(i); bd_data = 16'hA000 + 16'(i);
            exp_mem[16'h0040 + i] = 16'hA000 + 16'(i);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            bd_we = 1'b1; bd_addr = 16'h0020 + 16'(i); bd_data = 16'hB000 + 16'(i);
            tick();
        end
        bd_we = 1'b0;
        tick();

        // Fill at 0x0041 from preloaded words.
        clr();
        raddr = 16'h0041; re = 1'b1;
        tick();
        wait_dr(40);
        check("fill_req_count", 64'(rd_q.size()), 64'd4);
        for (int i = 0; i < rd_q.size() && i < 4; i++)
            check("fill_req_addr", {48'd0, rd_q[i].addr}, 64'h0040 + 64'(i));
        check("fill_latency", 64'(first_gap(dr_q.size() > 0 ? dr_q[0] : 0, rd_q.size(), rd_q.size() > 0 ? rd_q[0].cyc : 0)), 64'd16);
        check("fill_line", rline, 64'hA003_A002_A001_A000);
        exp_rline = rline;

        // Held level: no refill; drop and re-raise gives a second fill.
        repeat (30) tick();
        check("hold_one_pulse", 64'(dr_q.size()), 64'd1);
        check("hold_no_extra_req", 64'(rd_q.size()), 64'd4);
        re = 1'b0;
        tick();
        clr();
        re = 1'b1;
        tick();
        wait_dr(40);
        check("refill_pulses", 64'(dr_q.size()), 64'd1);
        check("refill_line", rline, 64'hA003_A002_A001_A000);
        re = 1'b0;
        tick();

        // Write-back of a known line to 0x0080.
        clr();
        waddr = 16'h0080; wline = 64'h4444_3333_2222_1111; we = 1'b1; c0 = cyc;
        tick();
        we = 1'b0;
        wait_idle(20);
        for (int i = 0; i < 4; i++) exp_mem[16'h0080 + i] = wline[i*16 +: 16];
        check("wb_count", 64'(wr_q.size()), 64'd4);
        for (int i = 0; i < wr_q.size() && i < 4; i++) begin
            check("wb_addr", {48'd0, wr_q[i].addr}, 64'h0080 + 64'(i));
            check("wb_data", {48'd0, wr_q[i].data}, {48'd0, exp_mem[16'h0080 + i]});
            check("wb_cycle", 64'(wr_q[i].cyc - c0), 64'(i + 1));
        end
        check("wb_busy_drop", 64'(cyc - c0), 64'd5);
        check("wb_hold_line", rline, exp_rline);

        // Same-cycle write-back and fill to the same line.
        clr();
        line = {$urandom(), $urandom()};
        waddr = 16'h0080; raddr = 16'h0080; wline = line; we = 1'b1; re = 1'b1; c0 = cyc;
        tick();
        we = 1'b0;
        wait_dr(40);
        for (int i = 0; i < 4; i++) exp_mem[16'h0080 + i] = line[i*16 +: 16];
        check("raw_wr_count", 64'(wr_q.size()), 64'd4);
        check("raw_order", {63'd0, wr_q.size() == 4 && rd_q.size() > 0 && wr_q[3].cyc < rd_q[0].cyc}, 64'd1);
        check("raw_ready_cycle", 64'(dr_q.size() > 0 ? dr_q[0] - (c0 + 1) : -1), 64'd20);
        check("raw_line", rline, exp_line(16'h0080));
        exp_rline = rline;
        re = 1'b0;
        tick();

        // Random write-backs and fills against the memory model.
        bases.push_back(16'h0040);
        bases.push_back(16'h0080);
        for (int k = 0; k < 30; k++) begin
            op = $urandom_range(0, 2);
            b  = 16'h0100 + 16'(4 * $urandom_range(0, 15));
            line = {$urandom(), $urandom()};
            rb = bases[$urandom_range(0, bases.size() - 1)] | 16'($urandom_range(0, 3));
            clr();
            if (op == 0) begin
                waddr = b | 16'($urandom_range(0, 3)); wline = line; we = 1'b1;
                tick();
                we = 1'b0;
                wait_idle(20);
                for (int i = 0; i < 4; i++) exp_mem[int'(b) + i] = line[i*16 +: 16];
                bases.push_back(b);
                check("rnd_wb_count", 64'(wr_q.size()), 64'd4);
                check("rnd_wb_hold", rline, exp_rline);
            end else if (op == 1) begin
                raddr = rb; re = 1'b1;
                tick();
                wait_dr(40);
                check("rnd_fill_latency", 64'(first_gap(dr_q.size() > 0 ? dr_q[0] : 0, rd_q.size(), rd_q.size() > 0 ? rd_q[0].cyc : 0)), 64'd16);
                check("rnd_fill_line", rline, exp_line(rb));
                exp_rline = rline;
                re = 1'b0;
                tick();
            end else begin
                if ($urandom_range(0, 1) == 1) rb = b | 16'($urandom_range(0, 3));
                waddr = b; wline = line; raddr = rb; we = 1'b1; re = 1'b1; c0 = cyc;
                tick();
                we = 1'b0;
                wait_dr(40);
                for (int i = 0; i < 4; i++) exp_mem[int'(b) + i] = line[i*16 +: 16];
                bases.push_back(b);
                check("rnd_raw_cycle", 64'(dr_q.size() > 0 ? dr_q[0] - (c0 + 1) : -1), 64'd20);
                check("rnd_raw_line", rline, exp_line(rb));
                exp_rline = rline;
                re = 1'b0;
                tick();
            end
        end

        // Reset while waiting on word 2 of a fill.
        clr();
        raddr = 16'h0080; re = 1'b1;
        tick();
        c0 = 0;
        while (rd_q.size() > 0 && cyc < rd_q[0].cyc + 9 && c0 < 20) begin tick(); c0++; end
        check("mid_rst_progress", 64'(rd_q.size()), 64'd3);
        #2;
        re = 1'b0; reset = 1'b1;
        #1;
        check("mid_rst_strobes", {61'd0, mre, mwe, dr}, 64'd0);
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        tick();
        reset = 1'b0;
        clr();
        repeat (30) tick();
        check("post_rst_quiet", 64'(dr_q.size() + rd_q.size() + wr_q.size()), 64'd0);
        check("post_rst_line", rline, 64'd0);
        check("post_rst_idle", {63'd0, busy}, 64'd0);

        // Two-word, latency-1 build.
        clr();
        raddr2 = 16'h0021; re2 = 1'b1;
        tick();
        c0 = 0;
        while (dr2_q.size() == 0 && c0 < 20) begin tick(); c0++; end
        check("b2_ready_seen", 64'(dr2_q.size()), 64'd1);
        check("b2_req_count", 64'(rd2_q.size()), 64'd2);
        check("b2_req_spacing", 64'(rd2_q.size() == 2 ? rd2_q[1] - rd2_q[0] : -1), 64'd2);
        check("b2_latency", 64'(dr2_q.size() > 0 && rd2_q.size() > 0 ? dr2_q[0] - rd2_q[0] : -1), 64'd4);
        check("b2_line", {32'd0, rline2}, {32'd0, 32'hB001_B000});
        re2 = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
